sd_spi_responder: RTL

Synthesizable SPI-mode SD card responder: the card end of the SD/SPI link that our SDIF host drives. It decodes 48-bit command frames on mosi and answers on miso with R1/R7 responses and CMD17 single-block read data fetched from a byte-wide memory port. It lets us close the loop on SDIF in simulation and on the board, with no physical card, by strapping it to the SD pins. All logic runs on the system clock; sclk, mosi and ss are oversampled.

---
 rtl/sd_spi_pkg.sv | 48 ++++
 rtl/sd_spi_bitif.sv | 86 ++++++++
 rtl/sd_spi_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types and constants for the SPI-mode SD card responder.
// Holds the responder state enum, command indices, R1 bit values, filler and
// data-token bytes, and the CRC-16-CCITT byte step used when
// SD_RESP_CRC16_EN is defined.
package sd_spi_pkg;

  // One state per phase of a transaction. The TX states name the byte that
  // goes into the shifter on the next byte-boundary fall. TX_END marks the
  // final byte as already loaded.
  typedef enum logic [3:0] {
    RX_WAIT  = 4'd0,
    RX_CMD   = 4'd1,
    WAIT_NCR = 4'd2,
    TX_R1    = 4'd3,
    TX_R7    = 4'd4,
    WAIT_NAC = 4'd5,
    TX_TOKEN = 4'd6,
    TX_DATA  = 4'd7,
    TX_CRC   = 4'd8,
    TX_END   = 4'd9
  } sd_state_e;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] R1_PARAM   = 8'h40;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL       = 8'hFF;

  // Advance a CRC-16-CCITT (poly 0x1021, MSB first) by one data byte
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_bitif.sv
// sd_spi_bitif: bit-level front end of the SD/SPI responder.
// Synchronises sclk/mosi/ss with 2-FF chains and detects sclk edges, which
// count only while ss is low. It also holds the 48-bit command shifter and
// the 8-bit MSB-first transmit shifter that drives miso.
module sd_spi_bitif
  import sd_spi_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        sclk_i,
  input  logic        mosi_i,
  input  logic        ss_i,
  input  logic        rx_shift_i,
  input  logic        tx_load_i,
  input  logic        tx_shift_i,
  input  logic        tx_clear_i,
  input  logic [7:0]  tx_byte_i,
  output logic        rise_o,
  output logic        fall_o,
  output logic        mosi_s_o,
  output logic        ss_s_o,
  output logic [47:0] frame_o,
  output logic        miso_o
);

  logic [1:0]  sclk_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [1:0]  ss_sync_q;
  logic        sclk_prev_q;
  logic [47:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        unused_rx;

  // Two-flop synchronisers plus a delayed copy of sclk for edge detection
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b11;
      ss_sync_q   <= 2'b11;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      ss_sync_q   <= {ss_sync_q[0], ss_i};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Edges are combinational so miso can move on the clock after detection.
  assign rise_o   = sclk_sync_q[1] & ~sclk_prev_q & ~ss_sync_q[1];
  assign fall_o   = ~sclk_sync_q[1] & sclk_prev_q & ~ss_sync_q[1];
  assign mosi_s_o = mosi_sync_q[1];
  assign ss_s_o   = ss_sync_q[1];

  // Command shifter: the parent decodes on the 48th rise, so frame_o already
  // includes the bit being sampled on that rise.
  always_comb begin
    rx_d = rx_q;
    if (rx_shift_i) rx_d = {rx_q[46:0], mosi_sync_q[1]};
  end

  assign frame_o   = {rx_q[46:0], mosi_sync_q[1]};
  assign unused_rx = rx_q[47];

  // Transmit shifter: clear (idle high) beats load, which beats shift.
  always_comb begin
    tx_d = tx_q;
    if (tx_clear_i)      tx_d = FILL;
    else if (tx_load_i)  tx_d = tx_byte_i;
    else if (tx_shift_i) tx_d = {tx_q[6:0], 1'b1};
  end

  // Shifter registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rx_q <= '0;
      tx_q <= FILL;
    end else begin
      rx_q <= rx_d;
      tx_q <= tx_d;
    end
  end

  assign miso_o = tx_q[7];

endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card end for closing the loop on the SDIF host.
// Decodes CMD0/8/17/55/ACMD41 and answers with R1 and R7 responses. For
// CMD17 it also sends one data block read from a byte-wide memory port.
// Optional SD_RESP_CRC16_EN: the two bytes after the block carry the real
// CRC-16-CCITT. Without it those two bytes are 0xFF.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int NCR_BYTES   = 1,
  parameter int NAC_BYTES   = 2,
  parameter int INIT_POLLS  = 2,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        initialized,
  output logic [5:0]  last_cmd,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  localparam logic [15:0] NCR_LAST   = 16'(NCR_BYTES - 1);
  localparam logic [15:0] NAC_LAST   = 16'(NAC_BYTES - 1);
  localparam logic [15:0] BLOCK_LAST = 16'(BLOCK_BYTES - 1);
  localparam logic [7:0]  POLLS_MAX  = 8'(INIT_POLLS);

  sd_state_e   state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_pos_q, bit_pos_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] arg_q, arg_d;
  logic [5:0]  last_cmd_q, last_cmd_d;
  logic        init_q, init_d;
  logic        app_q, app_d;
  logic [7:0]  polls_q, polls_d;
  logic        data_ph_q, data_ph_d;
  logic        is_cmd8_q, is_cmd8_d;
  logic [31:0] mem_addr_q, addr_d;
  logic        mem_rd_q, rd_d;
  logic        rd_pend_q;
  logic [7:0]  data_q;
`ifdef SD_RESP_CRC16_EN
  logic [15:0] crc_q, crc_d;
`endif

  logic        rise, fall, mosi_s, ss_s, miso_w;
  logic [47:0] frame;
  logic        rx_shift, tx_load, tx_shift, tx_clear;
  logic [7:0]  tx_byte, idle_bit;
  logic        unused_frame;

  sd_spi_bitif u_bitif (
    .clock_i   (clock),
    .reset_i   (reset),
    .sclk_i    (sclk),
    .mosi_i    (mosi),
    .ss_i      (ss),
    .rx_shift_i(rx_shift),
    .tx_load_i (tx_load),
    .tx_shift_i(tx_shift),
    .tx_clear_i(tx_clear),
    .tx_byte_i (tx_byte),
    .rise_o    (rise),
    .fall_o    (fall),
    .mosi_s_o  (mosi_s),
    .ss_s_o    (ss_s),
    .frame_o   (frame),
    .miso_o    (miso_w)
  );

  // Start/transmission bits were checked on the fly; CRC7 and stop are ignored
  assign unused_frame = ^{frame[47:46], frame[7:0]};

  // Memory port: mem_rd is a one-cycle strobe with mem_addr valid in the
  // same cycle. mem_rdata is captured exactly one clock later. No
  // backpressure exists, so each strobe is one completed read.

  // Next-state, command decode and byte sequencing
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_pos_d  = bit_pos_q;
    cnt_d      = cnt_q;
    r1_d       = r1_q;
    arg_d      = arg_q;
    last_cmd_d = last_cmd_q;
    init_d     = init_q;
    app_d      = app_q;
    polls_d    = polls_q;
    data_ph_d  = data_ph_q;
    is_cmd8_d  = is_cmd8_q;
    addr_d     = mem_addr_q;
    rd_d       = 1'b0;
`ifdef SD_RESP_CRC16_EN
    crc_d      = crc_q;
`endif
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_clear   = 1'b0;
    tx_byte    = FILL;
    idle_bit   = {7'd0, ~init_q};

    // The address advances after each strobe, ready for the next byte.
    if (mem_rd_q) addr_d = mem_addr_q + 32'd1;

    if (ss_s && (state_q != RX_WAIT)) begin
      // Host dropped the card mid-transaction: abandon it and idle miso high.
      state_d  = RX_WAIT;
      tx_clear = 1'b1;
    end else begin
      case (state_q)
        RX_WAIT: begin
          if (rise && !mosi_s) begin
            state_d   = RX_CMD;
            bit_cnt_d = 6'd1;
            rx_shift  = 1'b1;
          end
        end
        RX_CMD: begin
          if (rise) begin
            rx_shift = 1'b1;
            if ((bit_cnt_q == 6'd1) && !mosi_s) begin
              state_d = RX_WAIT;
            end else if (bit_cnt_q == 6'd47) begin
              state_d    = WAIT_NCR;
              cnt_d      = 16'd0;
              bit_pos_d  = 3'd7;
              last_cmd_d = frame[45:40];
              arg_d      = frame[39:8];
              is_cmd8_d  = 1'b0;
              data_ph_d  = 1'b0;
              app_d      = 1'b0;
              case (frame[45:40])
                CMD0: begin
                  r1_d    = R1_IDLE;
                  init_d  = 1'b0;
                  polls_d = 8'd0;
                end
                CMD8: begin
                  r1_d      = idle_bit;
                  is_cmd8_d = 1'b1;
                end
                CMD55: begin
                  r1_d  = idle_bit;
                  app_d = 1'b1;
                end
                CMD41: begin
                  if (!app_q) begin
                    r1_d = R1_ILLEGAL | idle_bit;
                  end else if (polls_q < POLLS_MAX) begin
                    r1_d    = R1_IDLE;
                    polls_d = polls_q + 8'd1;
                  end else begin
                    r1_d   = 8'h00;
                    init_d = 1'b1;
                  end
                end
                CMD17: begin
                  if (init_q) begin
                    r1_d      = 8'h00;
                    data_ph_d = 1'b1;
                    addr_d    = frame[39:8];
`ifdef SD_RESP_CRC16_EN
                    crc_d     = 16'h0000;
`endif
                  end else begin
                    r1_d = R1_ILLEGAL | idle_bit;
                  end
                end
                default: r1_d = R1_ILLEGAL | idle_bit;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        default: begin
          // Transmit states: shift on every fall, load a new byte after bit 0.
          if (fall) begin
            if (bit_pos_q != 3'd7) begin
              tx_shift  = 1'b1;
              bit_pos_d = bit_pos_q + 3'd1;
            end else begin
              tx_load   = 1'b1;
              bit_pos_d = 3'd0;
              cnt_d     = cnt_q + 16'd1;
              case (state_q)
                WAIT_NCR: begin
                  tx_byte = FILL;
                  if (cnt_q == NCR_LAST) begin
                    state_d = TX_R1;
                    cnt_d   = 16'd0;
                  end
                end
                TX_R1: begin
                  tx_byte = r1_q;
                  cnt_d   = 16'd0;
                  if (is_cmd8_q)      state_d = TX_R7;
                  else if (data_ph_q) state_d = WAIT_NAC;
                  else                state_d = TX_END;
                end
                TX_R7: begin
                  case (cnt_q[1:0])
                    2'd2:    tx_byte = {4'h0, arg_q[11:8]};
                    2'd3:    tx_byte = arg_q[7:0];
                    default: tx_byte = 8'h00;
                  endcase
                  if (cnt_q == 16'd3) state_d = TX_END;
                end
                WAIT_NAC: begin
                  tx_byte = FILL;
                  if (cnt_q == NAC_LAST) begin
                    state_d = TX_TOKEN;
                    cnt_d   = 16'd0;
                  end
                end
                TX_TOKEN: begin
                  tx_byte = DATA_TOKEN;
                  state_d = TX_DATA;
                  cnt_d   = 16'd0;
                  rd_d    = 1'b1;
                end
                TX_DATA: begin
                  tx_byte = data_q;
`ifdef SD_RESP_CRC16_EN
                  crc_d   = crc16_step(crc_q, data_q);
`endif
                  if (cnt_q == BLOCK_LAST) begin
                    state_d = TX_CRC;
                    cnt_d   = 16'd0;
                  end else begin
                    rd_d = 1'b1;
                  end
                end
                TX_CRC: begin
`ifdef SD_RESP_CRC16_EN
                  tx_byte = (cnt_q == 16'd0) ? crc_q[15:8] : crc_q[7:0];
`else
                  tx_byte = FILL;
`endif
                  if (cnt_q == 16'd1) state_d = TX_END;
                end
                default: begin
                  tx_byte = FILL;
                  state_d = RX_WAIT;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  // State and control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RX_WAIT;
      bit_cnt_q  <= 6'd0;
      bit_pos_q  <= 3'd0;
      cnt_q      <= 16'd0;
      r1_q       <= 8'h00;
      arg_q      <= 32'd0;
      last_cmd_q <= 6'd0;
      init_q     <= 1'b0;
      app_q      <= 1'b0;
      polls_q    <= 8'd0;
      data_ph_q  <= 1'b0;
      is_cmd8_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      data_q     <= 8'h00;
`ifdef SD_RESP_CRC16_EN
      crc_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_pos_q  <= bit_pos_d;
      cnt_q      <= cnt_d;
      r1_q       <= r1_d;
      arg_q      <= arg_d;
      last_cmd_q <= last_cmd_d;
      init_q     <= init_d;
      app_q      <= app_d;
      polls_q    <= polls_d;
      data_ph_q  <= data_ph_d;
      is_cmd8_q  <= is_cmd8_d;
      mem_addr_q <= addr_d;
      mem_rd_q   <= rd_d;
      rd_pend_q  <= mem_rd_q;
      if (rd_pend_q) data_q <= mem_rdata;
`ifdef SD_RESP_CRC16_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign miso        = miso_w;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign initialized = init_q;
  assign last_cmd    = last_cmd_q;
  assign busy        = (state_q != RX_WAIT);
  assign state_dbg   = state_q;

endmodule
